// File: rtl/sample_group_serializer_pkg.sv
// Shared sizes and small types for the sample group serializer.
package sample_group_serializer_pkg;

    localparam int unsigned SAMPLE_W = 48;
    localparam int unsigned GROUP_N  = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned GROUP_W  = SAMPLE_W * GROUP_N;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned SLOT_N   = 2;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam sel_t SEL_LAST = SEL_W'(GROUP_N - 1);
    localparam cnt_t CNT_FULL = CNT_W'(SLOT_N);

    // Sample selection index as a full-width integer for part-select math.
    function automatic int unsigned sel_base(input sel_t sel, input int unsigned w);
        return int'(sel) * w;
    endfunction

endpackage

// File: rtl/sample_group_serializer_mux.sv
// Eight-way sample selector: picks sample sel0 out of a packed group.
module mux_8_1
    import sample_group_serializer_pkg::*;
#(
    parameter int unsigned width = SAMPLE_W
) (
    input  logic [SEL_W-1:0]         sel0,
    input  logic [GROUP_N*width-1:0] in0,
    output logic [width-1:0]         out0
);

    // Decode one sample lane per select value.
    always_comb begin
        out0 = '0;
        for (int unsigned k = 0; k < GROUP_N; k++) begin
            if (sel0 == SEL_W'(k)) begin
                out0 = in0[k*width +: width];
            end
        end
    end

endmodule

// File: rtl/sample_group_serializer.sv
// Ping-pong buffer that takes 8-sample FFT groups and emits one sample per cycle.
module sample_group_serializer
    import sample_group_serializer_pkg::*;
#(
    parameter int unsigned width       = SAMPLE_W,
    parameter int unsigned width_group = GROUP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   grp_valid,
    output logic                   grp_ready,
    input  logic [width_group-1:0] grp_data,
    output logic                   smp_valid,
    input  logic                   smp_ready,
    output logic [width-1:0]       smp_data,
    output logic [SEL_W-1:0]       smp_idx,
    output logic                   smp_last
);

    localparam int unsigned GRP_W = GROUP_N * width;

    // Two group slots; contents are never reset, only the bookkeeping is.
    logic [GRP_W-1:0] slot_q [SLOT_N];

    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    sel_t sel_q, sel_d;

    logic accept_c;
    logic advance_c;
    logic release_c;
    logic [GRP_W-1:0] rd_group_c;

    // Handshake decode purely from registered state (plus reset gating).
    always_comb begin
        grp_ready = !rst && (count_q != CNT_FULL);
        smp_valid = !rst && (count_q != '0);
        smp_idx   = smp_valid ? sel_q : '0;
        smp_last  = smp_valid && (sel_q == SEL_LAST);
        accept_c  = grp_valid && grp_ready;
        advance_c = smp_valid && smp_ready;
        release_c = advance_c && (sel_q == SEL_LAST);
    end

    // Next-state for pointers, occupancy and sample counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sel_d    = sel_q;

        if (accept_c) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        if (advance_c) begin
            if (release_c) begin
                sel_d    = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end

        // Simultaneous accept and release leaves occupancy unchanged.
        case ({accept_c, release_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            sel_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sel_q    <= sel_d;
        end
    end

    // Slot write; the write slot is never the one being read while a group is held.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            slot_q[wr_ptr_q] <= grp_data[GRP_W-1:0];
        end
    end

    assign rd_group_c = slot_q[rd_ptr_q];

    mux_8_1 #(
        .width (width)
    ) u_mux (
        .sel0 (sel_q),
        .in0  (rd_group_c),
        .out0 (smp_data)
    );

endmodule

// File: tb/tb_sample_group_serializer.sv
// Directed bench for sample_group_serializer: cycle table plus corner sequences.
module tb_sample_group_serializer;

    logic         clk;
    logic         rst;
    logic         grp_valid;
    logic         grp_ready;
    logic [383:0] grp_data;
    logic         smp_valid;
    logic         smp_ready;
    logic [47:0]  smp_data;
    logic [2:0]   smp_idx;
    logic         smp_last;

    int n_cmp = 0;
    int n_bad = 0;
    int step_no = 0;

    sample_group_serializer #(
        .width       (48),
        .width_group (384)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .grp_valid (grp_valid),
        .grp_ready (grp_ready),
        .grp_data  (grp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .smp_idx   (smp_idx),
        .smp_last  (smp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        gv;
        logic [23:0] gbase;
        logic        sr;
        logic        ev;
        logic [2:0]  eidx;
        logic [23:0] ebase;
        logic        elast;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];

    // Sample k of a group built on base: real = base+k, imag = FFFFF0+k.
    function automatic logic [47:0] samp(input logic [23:0] base, input logic [2:0] k);
        return {base + 24'(k), 24'hFFFFF0 + 24'(k)};
    endfunction

    function automatic logic [383:0] make_group(input logic [23:0] base);
        logic [383:0] g;
        g = '0;
        for (int k = 0; k < 8; k++) g[k*48 +: 48] = samp(base, 3'(k));
        return g;
    endfunction

    function automatic vec_t mk(input string n, input logic r, input logic gv,
                                input logic [23:0] gb, input logic sr, input logic ev,
                                input logic [2:0] ei, input logic [23:0] eb,
                                input logic el, input logic er);
        vec_t v;
        v.name = n; v.rst = r; v.gv = gv; v.gbase = gb; v.sr = sr;
        v.ev = ev; v.eidx = ei; v.ebase = eb; v.elast = el; v.erdy = er;
        return v;
    endfunction

    function automatic void add(input string n, input logic r, input logic gv,
                                input logic [23:0] gb, input logic sr, input logic ev,
                                input logic [2:0] ei, input logic [23:0] eb,
                                input logic el, input logic er);
        vecs.push_back(mk(n, r, gv, gb, sr, ev, ei, eb, el, er));
    endfunction

    task automatic chk(input string what, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, what, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then compare outputs.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        grp_valid = v.gv;
        grp_data  = make_group(v.gbase);
        smp_ready = v.sr;
        #1;
        chk({v.name, ".smp_valid"}, 48'(smp_valid), 48'(v.ev));
        chk({v.name, ".smp_idx"},   48'(smp_idx),   48'(v.eidx));
        chk({v.name, ".smp_last"},  48'(smp_last),  48'(v.elast));
        chk({v.name, ".grp_ready"}, 48'(grp_ready), 48'(v.erdy));
        if (v.ev) chk({v.name, ".smp_data"}, smp_data, samp(v.ebase, v.eidx));
        step_no++;
    endtask

    task automatic step(input string n, input logic r, input logic gv,
                        input logic [23:0] gb, input logic sr, input logic ev,
                        input logic [2:0] ei, input logic [23:0] eb,
                        input logic el, input logic er);
        apply(mk(n, r, gv, gb, sr, ev, ei, eb, el, er));
    endtask

    initial begin
        rst       = 1'b1;
        grp_valid = 1'b0;
        grp_data  = '0;
        smp_ready = 1'b1;

        // Reset state.
        add("rst0", 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0);
        add("rst1", 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0);

        // Single group, free-running downstream.
        add("g0_offer", 1'b0, 1'b1, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            add("g0_smp", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h0, k == 7, 1'b1);
        add("g0_idle", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);

        // Three back-to-back groups; C stalls until A releases.
        add("abc_A", 1'b0, 1'b1, 24'h100, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
        add("abc_B", 1'b0, 1'b1, 24'h200, 1'b1, 1'b1, 3'd0, 24'h100, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++)
            add("abc_Cwait", 1'b0, 1'b1, 24'h300, 1'b1, 1'b1, 3'(k), 24'h100, k == 7, 1'b0);
        add("abc_Cacc", 1'b0, 1'b1, 24'h300, 1'b1, 1'b1, 3'd0, 24'h200, 1'b0, 1'b1);
        for (int k = 1; k < 8; k++)
            add("abc_Bsmp", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h200, k == 7, 1'b0);
        for (int k = 0; k < 8; k++)
            add("abc_Csmp", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h300, k == 7, 1'b1);
        add("abc_idle", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);

        // Backpressure for 5 cycles at idx 3.
        add("bp_offer", 1'b0, 1'b1, 24'h400, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            add("bp_pre", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h400, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++)
            add("bp_hold", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 3'd3, 24'h400, 1'b0, 1'b1);
        for (int k = 3; k < 8; k++)
            add("bp_post", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h400, k == 7, 1'b1);
        add("bp_idle", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Accept and release in the same cycle with one group held.
        step("ar_offE", 1'b0, 1'b1, 24'h500, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++)
            step("ar_E", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h500, 1'b0, 1'b1);
        step("ar_E7_offF", 1'b0, 1'b1, 24'h600, 1'b1, 1'b1, 3'd7, 24'h500, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++)
            step("ar_F", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h600, k == 7, 1'b1);
        step("ar_idle", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);

        // Reset pulse at idx 4 with two groups buffered.
        step("rs_G", 1'b0, 1'b1, 24'h700, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
        step("rs_H", 1'b0, 1'b1, 24'h800, 1'b1, 1'b1, 3'd0, 24'h700, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++)
            step("rs_Gsmp", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h700, 1'b0, 1'b0);
        step("rs_pulse", 1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0);
        step("rs_after", 1'b0, 1'b1, 24'h900, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            step("rs_J", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 3'(k), 24'h900, k == 7, 1'b1);
        step("rs_idle", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_group_serializer.md
SAMPLE_GROUP_SERIALIZER -- requirements
Module: sample_group_serializer

Interface
REQ-001 The block SHALL have parameter width, default 48, meaning bits per complex sample ({real[23:0], imag[23:0]}, real in the upper half).
REQ-002 The block SHALL have parameter width_group, default 384, meaning bits per group of 8 samples; sample k occupies bits [(k+1)*width-1 : k*width].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port grp_valid, input, 1 bit: upstream group present.
REQ-006 The block SHALL have port grp_ready, output, 1 bit: the block can accept a group this cycle.
REQ-007 The block SHALL have port grp_data, input, width_group bits: 8 parallel FFT samples.
REQ-008 The block SHALL have port smp_valid, output, 1 bit: smp_data holds a valid sample.
REQ-009 The block SHALL have port smp_ready, input, 1 bit: downstream accepts the sample.
REQ-010 The block SHALL have port smp_data, output, width bits: the current serialized sample.
REQ-011 The block SHALL have port smp_idx, output, 3 bits: the index 0..7 of the current sample within its group.
REQ-012 The block SHALL have port smp_last, output, 1 bit: high when smp_idx==7 and smp_valid is high.

Function
REQ-013 The block SHALL hold two group slots (ping-pong), a write pointer, a read pointer, an occupancy count 0..2 and a 3-bit sample counter sel.
REQ-014 grp_ready SHALL equal (count<2) and not rst, decoded from registered state with no combinational path from smp_ready.
REQ-015 On grp_valid&&grp_ready the block SHALL store grp_data into slot[wr_ptr] and toggle wr_ptr.
REQ-016 smp_valid SHALL equal (count>0); smp_data SHALL be sample sel of slot[rd_ptr]; smp_idx SHALL equal sel.
REQ-017 On smp_valid&&smp_ready with sel<7, sel SHALL increment.
REQ-018 On smp_valid&&smp_ready with sel==7, sel SHALL wrap to 0, rd_ptr SHALL toggle and the group SHALL be released.
REQ-019 If a group is accepted and a group is released in the same cycle, count SHALL stay unchanged; accept alone SHALL give count+1; release alone SHALL give count-1.
REQ-020 At count==2 with a release in progress, grp_ready SHALL stay 0 in that cycle, with no same-cycle bypass.
REQ-021 Latency SHALL be one cycle: a group accepted at edge N into an empty block SHALL present sample 0 with smp_valid=1 immediately after edge N.
REQ-022 Throughput SHALL be one sample per cycle sustained; with smp_ready held at 1 and groups offered continuously, smp_valid SHALL never drop between groups.
REQ-023 While smp_valid&&!smp_ready, smp_data, smp_idx and smp_last SHALL hold stable.
REQ-024 While smp_valid=0, smp_data content SHALL be don't-care, and smp_idx SHALL read 0.
REQ-025 A write into the slot currently being read SHALL be impossible by construction, because count<2 implies wr_ptr != rd_ptr whenever count==1.
REQ-026 No arithmetic SHALL be applied to samples; data SHALL pass bit-exact.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set count=0, wr_ptr=0, rd_ptr=0 and sel=0.
REQ-028 While rst=1, grp_ready, smp_valid and smp_last SHALL all be 0.
REQ-029 Slot contents SHALL NOT be reset.
REQ-030 Reset asserted mid-group SHALL discard all buffered groups and any partially serialized group; the first edge after rst deasserts SHALL find grp_ready=1 and smp_valid=0.

Structure
REQ-031 A shared package SHALL define SAMPLE_W=48, GROUP_N=8, SEL_W=3 and GROUP_W=SAMPLE_W*GROUP_N.
REQ-032 Sample selection SHALL be a single instance of mux_8_1 (sel0 driven by sel, in0 driven by slot[rd_ptr], out0 driving smp_data).
REQ-033 Slot storage, pointers and counters SHALL be local to this block.

Verification
REQ-034 Single group with sample k = {24'h00000k, 24'hFFFFF0+k} and smp_ready=1 -> smp_idx 0..7 on 8 consecutive cycles, exact data, smp_last only at idx 7, then smp_valid=0.
REQ-035 Three back-to-back groups (A, B, C) with smp_ready=1 -> 24 consecutive valid samples; grp_ready low from the edge C is attempted while A and B are held until A's idx-7 release, then C is accepted.
REQ-036 Backpressure with smp_ready low for 5 cycles at idx 3 -> smp_data and smp_idx held at 3 for all 5 cycles, no sample lost or duplicated.
REQ-037 Simultaneous accept and release with count==1 and sel==7 while grp_valid=1 -> count stays 1 and the next sample is idx 0 of the new group.
REQ-038 rst pulsed at idx 4 with 2 groups buffered -> next cycle smp_valid=0, grp_ready=1, and a new group starts at idx 0.
